// File: rtl/adder_pkg.sv
// Shared constants for the registered adder feeding axis_sum_tx:
// its pipeline depth and the width of the sum it produces.
package adder_pkg;

  localparam int ADDER_LATENCY = 2;

  function automatic int sum_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/axis_sum_tx_if.sv
// AXI-Stream bus carrying sums out of axis_sum_tx.
// The tlast wire exists only when AXIS_TLAST_EN is defined.
interface axis_sum_tx_if #(
  parameter int WIDTH = 4
) ();
  import adder_pkg::*;

  localparam int SW = sum_width(WIDTH);

  logic [SW-1:0] tdata;
  logic          tvalid;
  logic          tready;
`ifdef AXIS_TLAST_EN
  logic          tlast;

  modport master (output tdata, output tvalid, input tready, output tlast);
  modport slave  (input tdata, input tvalid, output tready, input tlast);
`else
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
`endif

endinterface

// File: rtl/axis_sum_tx_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; push and pop may coincide
// at any fill level, including full. Head data reads as zero while empty.
module sync_fifo #(
  parameter  int DW    = 5,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axis_sum_tx.sv
// Credit-controlled bridge from a registered adder to AXI-Stream: sums land in a FIFO
// two cycles after issue. Define AXIS_TLAST_EN to add tlast every PKT_LEN beats.
module axis_sum_tx
  import adder_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int PKT_LEN = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_i,
  output logic                        ready_o,
  input  logic [sum_width(WIDTH)-1:0] data_i,
  axis_sum_tx_if.master               m_axis
);

  localparam int SW = sum_width(WIDTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(ADDER_LATENCY + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_sum_tx: DEPTH must be a power of two and at least 2");
  end
  if (PKT_LEN < 1) begin : g_bad_pkt_len
    $error("axis_sum_tx: PKT_LEN must be at least 1");
  end

  logic [ADDER_LATENCY-1:0] vld_q, vld_d;
  logic [IW-1:0]            inflight_q, inflight_d;
  logic                     accept;
  logic                     fifo_wr;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [SW-1:0]            fifo_head;

  // Credits cover both stored sums and sums still inside the adder, so a write never overflows.
  always_comb begin
    ready_o  = (int'(fifo_count) + int'(inflight_q)) < DEPTH;
    accept   = issue_i && ready_o;
    fifo_pop = !fifo_empty && m_axis.tready;
    fifo_wr  = vld_q[ADDER_LATENCY-1] && (!fifo_full || fifo_pop);
    vld_d    = {vld_q[ADDER_LATENCY-2:0], accept};
    case ({accept, vld_q[ADDER_LATENCY-1]})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
    end
  end

  sync_fifo #(
    .DW    (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_wr),
    .push_data (data_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_head;

`ifdef AXIS_TLAST_EN
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [BW-1:0] beat_q, beat_d;

  // Counts completed handshakes only, so stalls never shift packet boundaries.
  always_comb begin
    beat_d = beat_q;
    if (fifo_pop) begin
      beat_d = (beat_q == BW'(PKT_LEN - 1)) ? '0 : beat_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  assign m_axis.tlast = !fifo_empty && (beat_q == BW'(PKT_LEN - 1));
`endif

endmodule

// File: tb/tb_axis_sum_tx.sv
// Scoreboard bench for axis_sum_tx: directed issues push expected sums, a negedge
// monitor pops and compares on every handshake. Covers AXIS_TLAST_EN when defined.
module tb_axis_sum_tx;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 4;
  localparam int PKT_LEN = 8;
  localparam int SW      = WIDTH + 1;

  typedef struct {
    logic [SW-1:0] data;
    int            cyc;
  } exp_t;

  logic             clk     = 1'b0;
  logic             reset   = 1'b0;
  logic             issue_i = 1'b0;
  logic             ready_o;
  logic [WIDTH-1:0] op_a    = '0;
  logic [WIDTH-1:0] op_b    = '0;
  logic [SW-1:0]    sum_s1  = '0;
  logic [SW-1:0]    sum_s2  = '0;
  logic [SW-1:0]    data_i;

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  axis_sum_tx_if #(.WIDTH(WIDTH)) m_axis ();

  axis_sum_tx #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .PKT_LEN (PKT_LEN)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .issue_i (issue_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .m_axis  (m_axis)
  );

  always #5 clk = ~clk;

  // Upstream registered adder: operands load on issue, sum appears two cycles later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (issue_i) sum_s1 <= {1'b0, op_a} + {1'b0, op_b};
    sum_s2 <= sum_s1;
  end
  assign data_i = sum_s2;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("[TB] FAIL %s: actual %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int a, input int b, input int sum, input bit exp_ready,
                               input bit chk_lat);
    exp_t e;
    op_a    = WIDTH'(a);
    op_b    = WIDTH'(b);
    issue_i = 1'b1;
    checkOutput("ready_o_at_issue", int'(ready_o), int'(exp_ready));
    if (exp_ready) begin
      e.data = SW'(sum);
      e.cyc  = chk_lat ? cyc + 3 : -1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    issue_i = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    checkOutput("drain_remaining", sb.size(), 0);
  endtask

  logic          hold_pend = 1'b0;
  logic [SW-1:0] hold_data = '0;
`ifdef AXIS_TLAST_EN
  int            beat_m    = 0;
`endif

  // Monitor: reset flushes expectations; every handshake must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      sb.delete();
      hold_pend = 1'b0;
`ifdef AXIS_TLAST_EN
      beat_m = 0;
`endif
    end else begin
      if (hold_pend) begin
        checkOutput("hold_tvalid", int'(m_axis.tvalid), 1);
        checkOutput("hold_tdata", int'(m_axis.tdata), int'(hold_data));
      end
      if (m_axis.tvalid && m_axis.tready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_beat: actual tdata %0d, required no beat (cycle %0d)",
                   m_axis.tdata, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("tdata", int'(m_axis.tdata), int'(e.data));
          if (e.cyc >= 0) checkOutput("tvalid_cycle", cyc, e.cyc);
`ifdef AXIS_TLAST_EN
          checkOutput("tlast", int'(m_axis.tlast), int'(beat_m == PKT_LEN - 1));
`endif
        end
`ifdef AXIS_TLAST_EN
        beat_m = (beat_m == PKT_LEN - 1) ? 0 : beat_m + 1;
`endif
      end
      hold_pend = m_axis.tvalid && !m_axis.tready;
      hold_data = m_axis.tdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int full_vec [6][4];
    full_vec = '{'{1, 2, 3, 1}, '{2, 3, 5, 1}, '{3, 4, 7, 1},
                 '{5, 6, 11, 1}, '{7, 7, 14, 0}, '{15, 15, 30, 0}};

    m_axis.tready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_tvalid", int'(m_axis.tvalid), 0);
    checkOutput("rst_ready", int'(ready_o), 1);
    checkOutput("rst_tdata", int'(m_axis.tdata), 0);
`ifdef AXIS_TLAST_EN
    checkOutput("rst_tlast", int'(m_axis.tlast), 0);
`endif

    // Single 4+1 issue: tvalid only in the third cycle after issue.
    @(posedge clk);
    #1 m_axis.tready = 1'b1;
    applyStimulus(4, 1, 5, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput("single_tvalid", int'(m_axis.tvalid), int'(k == 3));
    end

    // Backpressure: four credits, then issues (including 15+15) are refused.
    @(posedge clk);
    #1 m_axis.tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(full_vec[i][0], full_vec[i][1], full_vec[i][2], full_vec[i][3] != 0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full_ready", int'(ready_o), 0);
    m_axis.tready = 1'b1;
    waitDrain(30);

    // Reset pulse one cycle after two issues discards both sums.
    @(posedge clk);
    #1;
    applyStimulus(2, 3, 5, 1'b1, 1'b0);
    applyStimulus(6, 1, 7, 1'b1, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("post_rst_tvalid", int'(m_axis.tvalid), 0);
    end
    checkOutput("post_rst_ready", int'(ready_o), 1);

    // Sixteen back-to-back sums at full rate, each three cycles after issue.
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(i, 1, i + 1, 1'b1, 1'b1);
    end
    waitDrain(20);

    // Toggling tready with an issue every other cycle; tlast follows handshakes.
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk);
          #1 m_axis.tready = ~m_axis.tready;
        end
      end
      begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          applyStimulus(i + 2, 3, i + 5, 1'b1, 1'b0);
          @(posedge clk);
          #1;
        end
      end
    join
    m_axis.tready = 1'b1;
    waitDrain(20);
    repeat (2) @(negedge clk);
    checkOutput("idle_tvalid", int'(m_axis.tvalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
